// File: rtl/conv_pkg.sv
// Shared conv1 constants: word width, default feature-map geometry and kernel size.
package conv_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned CONV1_IMG_WIDTH  = 28;
    localparam int unsigned CONV1_IMG_HEIGHT = 28;
    localparam int unsigned KERNEL_SIZE      = 3;
    localparam int unsigned WIN_SIZE         = KERNEL_SIZE * KERNEL_SIZE;

    typedef logic [DATA_W-1:0] fp32_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of storage addressed by column; combinational read, synchronous write
// so a read and write at the same address return the previous row's word.
module line_buffer #(
    parameter int unsigned DEPTH  = 28,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata_c = mem[addr];

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv1_window_gen.sv
// Raster-order pixel stream to 3x3 sliding windows for the conv1 filter bank.
// Two chained line buffers hold rows r-1 and r-2; a 3x3 shift register forms the window.
module conv1_window_gen #(
    parameter int unsigned IMG_WIDTH  = conv_pkg::CONV1_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = conv_pkg::CONV1_IMG_HEIGHT,
    parameter int unsigned DATA_W     = conv_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid,
    input  logic                          pix_sof,
    input  logic [DATA_W-1:0]             pix_data,
    output logic                          win_valid,
    output logic [DATA_W-1:0]             win_out [0:8],
    output logic                          frame_done,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_idx,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_idx
);

    import conv_pkg::*;

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;
    logic [CW-1:0]     next_col;
    logic [RW-1:0]     next_row;
    logic              last_col;
    logic              last_row;
    logic              in_window;
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;

    // Position of the incoming pixel; start-of-frame forces (0,0) and the buffer pointer to 0.
    always_comb begin
        cur_col = col_idx;
        cur_row = row_idx;
        if (pix_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
        last_col  = (cur_col == CW'(IMG_WIDTH - 1));
        last_row  = (cur_row == RW'(IMG_HEIGHT - 1));
        next_col  = last_col ? '0 : cur_col + CW'(1);
        next_row  = cur_row;
        if (last_col) begin
            next_row = last_row ? '0 : cur_row + RW'(1);
        end
        in_window = (cur_row >= RW'(KERNEL_SIZE - 1)) && (cur_col >= CW'(KERNEL_SIZE - 1));
    end

    line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .wr_en   (pix_valid),
        .addr    (cur_col),
        .wdata   (pix_data),
        .rdata_c (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .wr_en   (pix_valid),
        .addr    (cur_col),
        .wdata   (lb0_rd),
        .rdata_c (lb1_rd)
    );

    // Counters, window shift and strobes; the window shifts on every accept so that
    // windows straddling a row boundary exist but are never flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            row_idx    <= '0;
            col_idx    <= '0;
            for (int k = 0; k < WIN_SIZE; k++) begin
                win_out[k] <= '0;
            end
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                col_idx    <= next_col;
                row_idx    <= next_row;
                win_valid  <= in_window;
                frame_done <= in_window && last_row && last_col;
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    win_out[k*KERNEL_SIZE]     <= win_out[k*KERNEL_SIZE + 1];
                    win_out[k*KERNEL_SIZE + 1] <= win_out[k*KERNEL_SIZE + 2];
                end
                win_out[2] <= lb1_rd;
                win_out[5] <= lb0_rd;
                win_out[8] <= pix_data;
            end
        end
    end

endmodule

// File: tb/tb_conv1_window_gen.sv
// Bench for conv1_window_gen: a 5x4 instance for directed frames and a 28x28 instance
// for a random frame, both checked every cycle against an image-array reference.
module tb_conv1_window_gen;

    localparam int unsigned SW = 5;
    localparam int unsigned SH = 4;
    localparam int unsigned BW = 28;
    localparam int unsigned BH = 28;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic        pix_sof;
    logic [31:0] pix_data;
    logic        sel;
    logic        pv_s;
    logic        pv_b;

    always #5 clk = ~clk;

    assign pv_s = pix_valid & ~sel;
    assign pv_b = pix_valid & sel;

    logic        wv_s, fd_s, wv_b, fd_b;
    logic [31:0] win_s [0:8];
    logic [31:0] win_b [0:8];
    logic [1:0]  row_s;
    logic [2:0]  col_s;
    logic [4:0]  row_b;
    logic [4:0]  col_b;

    conv1_window_gen #(.IMG_WIDTH(SW), .IMG_HEIGHT(SH), .DATA_W(32)) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_valid(pv_s), .pix_sof(pix_sof), .pix_data(pix_data),
        .win_valid(wv_s), .win_out(win_s), .frame_done(fd_s), .row_idx(row_s), .col_idx(col_s)
    );

    conv1_window_gen #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH), .DATA_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_valid(pv_b), .pix_sof(pix_sof), .pix_data(pix_data),
        .win_valid(wv_b), .win_out(win_b), .frame_done(fd_b), .row_idx(row_b), .col_idx(col_b)
    );

    // Outputs of whichever instance is currently being exercised.
    logic             wv, fd, acc;
    logic [8:0][31:0] cw;
    int               cr, cc, mw, mh;

    always_comb begin
        wv  = sel ? wv_b : wv_s;
        fd  = sel ? fd_b : fd_s;
        acc = sel ? pv_b : pv_s;
        cr  = sel ? int'(row_b) : int'(row_s);
        cc  = sel ? int'(col_b) : int'(col_s);
        mw  = sel ? int'(BW) : int'(SW);
        mh  = sel ? int'(BH) : int'(SH);
        for (int k = 0; k < 9; k++) begin
            cw[k] = sel ? win_b[k] : win_s[k];
        end
    end

    // Reference: store every pixel at its (row, col) and cut the 3x3 block ending there.
    logic [31:0]      img [0:BH-1][0:BW-1];
    int               mr, mc;
    logic             exp_valid, exp_done;
    logic [8:0][31:0] exp_win;

    always @(posedge clk or negedge rst_n) begin : model
        int r, c;
        if (!rst_n) begin
            mr        <= 0;
            mc        <= 0;
            exp_valid <= 1'b0;
            exp_done  <= 1'b0;
        end else if (acc) begin
            r = pix_sof ? 0 : mr;
            c = pix_sof ? 0 : mc;
            if (r >= 2 && c >= 2) begin
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        exp_win[dr*3+dc] <= (dr == 2 && dc == 2) ? pix_data : img[r-2+dr][c-2+dc];
                    end
                end
            end
            img[r][c] <= pix_data;
            exp_valid <= (r >= 2 && c >= 2);
            exp_done  <= (r == mh - 1 && c == mw - 1);
            if (c == mw - 1) begin
                mc <= 0;
                mr <= (r == mh - 1) ? 0 : r + 1;
            end else begin
                mc <= c + 1;
                mr <= r;
            end
        end else begin
            exp_valid <= 1'b0;
            exp_done  <= 1'b0;
        end
    end

    int               checks = 0;
    int               failures = 0;
    int               ndone = 0;
    logic [8:0][31:0] seen [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("win_valid", 64'(wv), 64'(exp_valid));
            chk("frame_done", 64'(fd), 64'(exp_done));
            chk("row_idx", 64'(cr), 64'(mr));
            chk("col_idx", 64'(cc), 64'(mc));
            if (wv && exp_valid) begin
                for (int k = 0; k < 9; k++) begin
                    chk($sformatf("win_out[%0d]", k), 64'(cw[k]), 64'(exp_win[k]));
                end
            end
            if (wv) seen.push_back(cw);
            if (fd) ndone++;
        end
    end

    logic [31:0] a_first [9] = '{32'h00, 32'h01, 32'h02, 32'h10, 32'h11, 32'h12, 32'h20, 32'h21, 32'h22};
    logic [31:0] a_last  [9] = '{32'h12, 32'h13, 32'h14, 32'h22, 32'h23, 32'h24, 32'h32, 32'h33, 32'h34};
    logic [31:0] b_first [9] = '{32'h100, 32'h101, 32'h102, 32'h110, 32'h111, 32'h112, 32'h120, 32'h121, 32'h122};
    logic [31:0] c_first [9] = '{32'h200, 32'h201, 32'h202, 32'h210, 32'h211, 32'h212, 32'h220, 32'h221, 32'h222};
    logic [31:0] c_last  [9] = '{32'h212, 32'h213, 32'h214, 32'h222, 32'h223, 32'h224, 32'h232, 32'h233, 32'h234};

    task automatic check_win(input string nm, input int idx, input logic [31:0] lit [9]);
        chk({nm, "_present"}, 64'(seen.size() > idx), 64'(1));
        if (seen.size() > idx) begin
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("%s[%0d]", nm, k), 64'(seen[idx][k]), 64'(lit[k]));
            end
        end
    endtask

    task automatic put(input logic v, input logic s, input logic [31:0] d);
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic small_frame(input logic [31:0] base, input logic sof, input logic gaps);
        for (int r = 0; r < int'(SH); r++) begin
            for (int c = 0; c < int'(SW); c++) begin
                put(1'b1, sof && r == 0 && c == 0, base + 32'(r*16 + c));
                if (gaps) put(1'b0, 1'b0, 32'h0);
            end
        end
    endtask

    int b, d0;

    initial begin
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = '0;
        sel       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win_valid", 64'(wv_s), 64'(0));
        chk("rst_frame_done", 64'(fd_s), 64'(0));
        chk("rst_row_idx", 64'(row_s), 64'(0));
        chk("rst_col_idx", 64'(col_s), 64'(0));
        chk("rst_big_col_idx", 64'(col_b), 64'(0));
        for (int k = 0; k < 9; k++) chk($sformatf("rst_win_out[%0d]", k), 64'(win_s[k]), 64'(0));
        rst_n = 1'b1;
        put(1'b0, 1'b0, 32'h0);

        // Continuous frame with start-of-frame.
        b = seen.size(); d0 = ndone;
        small_frame(32'h0, 1'b1, 1'b0);
        repeat (2) put(1'b0, 1'b0, 32'h0);
        chk("s1_windows", 64'(seen.size() - b), 64'(6));
        chk("s1_frame_done", 64'(ndone - d0), 64'(1));
        check_win("s1_first", b, a_first);
        check_win("s1_last", b + 5, a_last);

        // Same frame with an idle cycle after every pixel.
        b = seen.size(); d0 = ndone;
        small_frame(32'h0, 1'b1, 1'b1);
        repeat (2) put(1'b0, 1'b0, 32'h0);
        chk("s2_windows", 64'(seen.size() - b), 64'(6));
        chk("s2_frame_done", 64'(ndone - d0), 64'(1));
        check_win("s2_first", b, a_first);
        check_win("s2_last", b + 5, a_last);

        // Two frames back to back; second without start-of-frame.
        b = seen.size(); d0 = ndone;
        small_frame(32'h0, 1'b1, 1'b0);
        small_frame(32'h100, 1'b0, 1'b0);
        repeat (2) put(1'b0, 1'b0, 32'h0);
        chk("s3_windows", 64'(seen.size() - b), 64'(12));
        chk("s3_frame_done", 64'(ndone - d0), 64'(2));
        check_win("s3_f2_first", b + 6, b_first);

        // Frame abandoned by start-of-frame at pixel (2,3).
        b = seen.size(); d0 = ndone;
        for (int p = 0; p < 13; p++) put(1'b1, p == 0, 32'((p / 5) * 16 + p % 5));
        small_frame(32'h200, 1'b1, 1'b0);
        repeat (2) put(1'b0, 1'b0, 32'h0);
        chk("s4_windows", 64'(seen.size() - b), 64'(7));
        chk("s4_frame_done", 64'(ndone - d0), 64'(1));
        check_win("s4_partial", b, a_first);
        check_win("s4_first", b + 1, c_first);
        check_win("s4_last", b + 6, c_last);

        // Reset after pixel (3,1), then a frame without start-of-frame.
        b = seen.size(); d0 = ndone;
        for (int p = 0; p < 17; p++) put(1'b1, p == 0, 32'((p / 5) * 16 + p % 5));
        rst_n = 1'b0;
        #1;
        chk("s5_rst_win_valid", 64'(wv_s), 64'(0));
        chk("s5_rst_frame_done", 64'(fd_s), 64'(0));
        chk("s5_rst_row_idx", 64'(row_s), 64'(0));
        chk("s5_rst_col_idx", 64'(col_s), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        small_frame(32'h0, 1'b0, 1'b0);
        repeat (2) put(1'b0, 1'b0, 32'h0);
        chk("s5_windows", 64'(seen.size() - b), 64'(9));
        chk("s5_frame_done", 64'(ndone - d0), 64'(1));
        check_win("s5_first", b + 3, a_first);
        check_win("s5_last", b + 8, a_last);

        // Full-size frame with random data.
        sel = 1'b1;
        put(1'b0, 1'b0, 32'h0);
        b = seen.size(); d0 = ndone;
        for (int p = 0; p < int'(BW * BH); p++) put(1'b1, p == 0, $urandom);
        repeat (2) put(1'b0, 1'b0, 32'h0);
        chk("s6_windows", 64'(seen.size() - b), 64'(676));
        chk("s6_frame_done", 64'(ndone - d0), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
